// File: rtl/inst_loader.sv
// Byte-stream program loader: packs incoming bytes little-endian into 32-bit
// words and writes WORDS of them into the instruction memory from address 0.
module inst_loader #(
    parameter int unsigned WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [5:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [6:0]  word_count
);

    localparam int unsigned CNT_W  = 7;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ASM_W  = 24;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_byte_cnt;
    logic [ASM_W-1:0]    r_asm;
    logic [CNT_W-1:0]    r_word_count;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                w_start;
    logic                w_accept;

    // start is only honoured outside LOAD
    assign w_start  = start && (r_state != S_LOAD);
    assign w_accept = byte_valid && byte_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; word_count reaches WORDS only in the last write cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_LOAD;
            S_LOAD:  if (r_word_count == LAST_CNT) w_state_nxt = S_DONE;
            S_DONE:  if (start) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State decode; intake closes during the final write so no byte leaks past the last word
    always_comb begin
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_LOAD: begin
                busy       = 1'b1;
                byte_ready = (r_word_count != LAST_CNT);
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Byte assembly and write strobe generation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt   <= 2'd0;
            r_asm        <= '0;
            r_word_count <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_start) begin
                r_byte_cnt   <= 2'd0;
                r_asm        <= '0;
                r_word_count <= '0;
            end else if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                case (r_byte_cnt)
                    2'd0: r_asm[7:0]   <= byte_in;
                    2'd1: r_asm[15:8]  <= byte_in;
                    2'd2: r_asm[23:16] <= byte_in;
                    default: begin
                        r_wr_en      <= 1'b1;
                        r_wr_addr    <= ADDR_W'(r_word_count);
                        r_wr_data    <= {byte_in, r_asm};
                        r_word_count <= r_word_count + 7'd1;
                    end
                endcase
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign word_count = r_word_count;

endmodule
